// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack, decode output slot
// and the downstream redirect port.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory one word at a
// time and holds one fetched instruction for decode; handles redirects/flushes.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'h3;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        req;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        valid_q;
  logic [31:0] target;

  assign target          = bus.redirect_target & ~32'h3;
  assign bus.imem_req    = req;
  assign bus.imem_addr   = req_addr;
  assign bus.instruction = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_ADDR;
      req_addr   <= RESET_ADDR;
      req        <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!req) begin
            // First cycle after reset: raise the request, honouring an early redirect
            req <= 1'b1;
            if (bus.redirect_valid) begin
              pc       <= target;
              req_addr <= target;
            end
          end else if (bus.imem_ack) begin
            if (bus.redirect_valid) begin
              pc       <= target;
              req_addr <= target;
            end else begin
              instr_q    <= bus.imem_rdata;
              instr_pc_q <= req_addr;
              valid_q    <= 1'b1;
              pc         <= req_addr + 32'd4;
              req        <= 1'b0;
              state      <= WAIT;
            end
          end else if (bus.redirect_valid) begin
            // Request must stay stable until acked; its data is dropped in FLUSH
            pc    <= target;
            state <= FLUSH;
          end
        end

        WAIT: begin
          if (bus.redirect_valid) begin
            valid_q  <= 1'b0;
            pc       <= target;
            req_addr <= target;
            req      <= 1'b1;
            state    <= FETCH;
          end else if (valid_q && bus.instr_ready) begin
            valid_q  <= 1'b0;
            req_addr <= pc;
            req      <= 1'b1;
            state    <= FETCH;
          end
        end

        FLUSH: begin
          if (bus.imem_ack) begin
            req_addr <= bus.redirect_valid ? target : pc;
            if (bus.redirect_valid) pc <= target;
            state <= FETCH;
          end else if (bus.redirect_valid) begin
            pc <= target;
          end
        end

        default: begin
          state   <= FETCH;
          req     <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed stimulus, a transaction
// model checked every cycle, and literal expectations on the delivered stream.
module tb_instr_fetch_unit;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ack_en = 1'b1;
  logic        ready  = 1'b1;
  logic        redir  = 1'b0;
  logic [31:0] tgt    = '0;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus2 ();

  // Memory responders: data word is the bitwise inverse of its address
  assign bus.imem_ack        = ack_en & bus.imem_req;
  assign bus.imem_rdata      = ~bus.imem_addr;
  assign bus.instr_ready     = ready;
  assign bus.redirect_valid  = redir;
  assign bus.redirect_target = tgt;

  assign bus2.imem_ack        = bus2.imem_req;
  assign bus2.imem_rdata      = ~bus2.imem_addr;
  assign bus2.instr_ready     = 1'b1;
  assign bus2.redirect_valid  = 1'b0;
  assign bus2.redirect_target = '0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cycle     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Transaction model: what must be requested next, whether the outstanding
  // request is doomed, and what the output slot must hold.
  logic        exp_req, exp_valid, discard;
  logic [31:0] exp_addr, nxt, slot_pc, slot_data;
  logic [31:0] pc_log[$];
  logic [31:0] data_log[$];
  int          cyc_log[$];
  logic [31:0] pc2_log[$];
  logic [31:0] data2_log[$];

  always @(negedge clk) begin
    logic [31:0] t;
    logic [31:0] a;
    cycle++;
    if (!rst_n) begin
      chk("rst_req", bus.imem_req, 32'd0);
      chk("rst_valid", bus.instr_valid, 32'd0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      exp_req = 1'b0; exp_valid = 1'b0; discard = 1'b0;
      exp_addr = 32'h0; nxt = 32'h0;
    end else begin
      chk("req", bus.imem_req, {31'd0, exp_req});
      chk("valid", bus.instr_valid, {31'd0, exp_valid});
      if (exp_req) chk("addr", bus.imem_addr, exp_addr);
      if (exp_valid) begin
        chk("slot_pc", bus.instr_pc, slot_pc);
        chk("slot_data", bus.instruction, slot_data);
      end
      t = tgt & ~32'h3;
      if (!exp_req && !exp_valid) begin
        exp_req = 1'b1;
        if (redir) begin exp_addr = t; nxt = t; end
      end else if (exp_req) begin
        if (ack_en) begin
          if (redir || discard) begin
            a = redir ? t : nxt;
            exp_addr = a; nxt = a; discard = 1'b0;
          end else begin
            slot_pc = exp_addr; slot_data = ~exp_addr;
            exp_valid = 1'b1; exp_req = 1'b0; nxt = exp_addr + 32'd4;
          end
        end else if (redir) begin
          discard = 1'b1; nxt = t;
        end
      end else begin
        if (redir) begin
          exp_valid = 1'b0; exp_req = 1'b1; exp_addr = t; nxt = t;
        end else if (ready) begin
          pc_log.push_back(slot_pc); data_log.push_back(slot_data); cyc_log.push_back(cycle);
          exp_valid = 1'b0; exp_req = 1'b1; exp_addr = nxt;
        end
      end
    end
    if (rst_n && bus2.instr_valid && pc2_log.size() < 2) begin
      pc2_log.push_back(bus2.instr_pc);
      data2_log.push_back(bus2.instruction);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] addr);
    bit found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.imem_req && bus.imem_addr == addr) found = 1'b1;
      else step();
    end
    if (!found) begin
      total_cnt++;
      $display("FAIL wait_req: no request seen, required addr %h", addr);
    end
  endtask

  int n;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_req", bus.imem_req, 32'd0);
    chk("reset_addr", bus.imem_addr, 32'h0);
    chk("reset_instr", bus.instruction, 32'h0);
    chk("reset_instr_pc", bus.instr_pc, 32'h0);
    chk("reset_valid", bus.instr_valid, 32'd0);
    chk("reset_addr_wrap", bus2.imem_addr, 32'hFFFF_FFFC);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("first_req", bus.imem_req, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);

    // Zero-wait stream until the fetch of 0x10 is on the bus
    wait_req(32'h10);
    chk("stream_count", pc_log.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
    chk("stream0_pc", pc_log[0], 32'h0);
    chk("stream0_data", data_log[0], 32'hFFFF_FFFF);
    chk("stream1_pc", pc_log[1], 32'h4);
    chk("stream1_data", data_log[1], 32'hFFFF_FFFB);
    chk("stream2_pc", pc_log[2], 32'h8);
    chk("stream2_data", data_log[2], 32'hFFFF_FFF7);
    chk("stream_gap01", cyc_log[1] - cyc_log[0], 32'd2);
    chk("stream_gap12", cyc_log[2] - cyc_log[1], 32'd2);

    // Backpressure on the 0x10 instruction
    ready = 1'b0;
    repeat (5) begin
      step();
      chk("bp_valid", bus.instr_valid, 32'd1);
      chk("bp_instr", bus.instruction, 32'hFFFF_FFEF);
      chk("bp_pc", bus.instr_pc, 32'h10);
      chk("bp_req", bus.imem_req, 32'd0);
    end
    ready = 1'b1;
    step();
    chk("bp_next_req", bus.imem_req, 32'd1);
    chk("bp_next_addr", bus.imem_addr, 32'h14);

    // Redirect on the ack cycle of 0x14 (unaligned target)
    redir = 1'b1; tgt = 32'h103;
    step();
    redir = 1'b0;
    chk("ackredir_addr", bus.imem_addr, 32'h100);
    chk("ackredir_valid", bus.instr_valid, 32'd0);
    step();
    chk("wait_slot_pc", bus.instr_pc, 32'h100);
    n = pc_log.size();
    redir = 1'b1; tgt = 32'h40; ready = 1'b1;
    step();
    redir = 1'b0; ready = 1'b0;
    chk("waitredir_addr", bus.imem_addr, 32'h40);
    chk("waitredir_valid", bus.instr_valid, 32'd0);
    chk("waitredir_no_xfer", pc_log.size(), n);

    // Redirect while the request for 0x8 is outstanding
    step();
    redir = 1'b1; tgt = 32'h8;
    step();
    redir = 1'b0; ack_en = 1'b0;
    chk("flush_addr0", bus.imem_addr, 32'h8);
    redir = 1'b1; tgt = 32'h200;
    step();
    redir = 1'b0;
    chk("flush_addr1", bus.imem_addr, 32'h8);
    step();
    chk("flush_addr2", bus.imem_addr, 32'h8);
    chk("flush_valid", bus.instr_valid, 32'd0);
    ack_en = 1'b1;
    step();
    chk("flush_next_req", bus.imem_req, 32'd1);
    chk("flush_next_addr", bus.imem_addr, 32'h200);
    n = pc_log.size();
    ready = 1'b1;
    step();
    chk("post_flush_pc", bus.instr_pc, 32'h200);
    chk("post_flush_instr", bus.instruction, 32'hFFFF_FDFF);
    step();
    chk("post_flush_count", pc_log.size(), n + 1);
    chk("post_flush_log", pc_log[n], 32'h200);

    // Flush drained by an ack that coincides with a newer redirect
    ack_en = 1'b0; redir = 1'b1; tgt = 32'h300;
    step();
    redir = 1'b0;
    step();
    redir = 1'b1; tgt = 32'h400; ack_en = 1'b1;
    step();
    redir = 1'b0;
    chk("flush_redir_addr", bus.imem_addr, 32'h400);
    step();
    chk("flush_redir_pc", bus.instr_pc, 32'h400);
    chk("flush_redir_valid", bus.instr_valid, 32'd1);

    // Asynchronous reset mid-stream while the slot is full
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req", bus.imem_req, 32'd0);
    chk("midrst_valid", bus.instr_valid, 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("midrst_first_req", bus.imem_req, 32'd1);
    chk("midrst_first_addr", bus.imem_addr, 32'h0);
    repeat (4) step();

    chk("wrap_count", pc2_log.size(), 32'd2);
    chk("wrap0_pc", pc2_log[0], 32'hFFFF_FFFC);
    chk("wrap0_data", data2_log[0], 32'h0000_0003);
    chk("wrap1_pc", pc2_log[1], 32'h0);
    chk("wrap1_data", data2_log[1], 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit that produces the 32-bit instruction stream consumed by the control unit and the rest of the decode stage. It owns the program counter, issues word reads to instruction memory over a request/acknowledge handshake, and buffers one fetched instruction in an output slot with a valid/ready handshake toward decode. Branch and jump redirects resolved downstream are accepted on a single redirect port, with correct discard of any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset. Bits [1:0] are treated as 0.
- clk  in  1  Single clock; all state updates on its rising edge.
- rst_n  in  1  Reset, asynchronous assert, active-low.
- imem_req  out  1  Read request to instruction memory.
- imem_addr  out  32  Word-aligned read address. Bits [1:0] are always 0.
- imem_ack  in  1  Memory completes the current request this cycle. Only meaningful while imem_req=1.
- imem_rdata  in  32  Read data, valid in the cycle where imem_ack=1.
- instruction  out  32  Buffered instruction word presented to decode.
- instr_pc  out  32  Address the buffered instruction was fetched from.
- instr_valid  out  1  Output slot holds a valid instruction.
- instr_ready  in  1  Decode accepts the slot this cycle.
- redirect_valid  in  1  Branch taken or jump. Fetch continues from redirect_target.
- redirect_target  in  32  New PC. Bits [1:0] are ignored and forced to 0.

## Operation
- Registers:
  - pc: next fetch address.
  - req_addr: drives imem_addr.
  - Output slot: instruction, instr_pc, instr_valid.
  - 2-bit state.
- States:
  - FETCH: imem_req=1. Request outstanding.
  - WAIT: slot full, no request.
  - FLUSH: request outstanding whose data must be discarded.
- Request rule: once imem_req=1, imem_req and imem_addr hold stable until the cycle imem_ack=1.
- FETCH transitions:
  - ack, no redirect: load instruction←imem_rdata, instr_pc←req_addr, instr_valid←1, pc←req_addr+4, imem_req←0, go to WAIT.
  - ack with redirect: discard the data. pc←target, req_addr←target, stay in FETCH (new request next cycle).
  - No ack, with redirect: pc←target, go to FLUSH. Request is held unchanged.
- WAIT transitions:
  - redirect_valid=1: instr_valid←0, pc←target, req_addr←target, imem_req←1, go to FETCH. Redirect has priority over instr_ready. No transfer occurs in that cycle.
  - instr_valid && instr_ready, no redirect: transfer occurs. instr_valid←0, req_addr←pc, imem_req←1, go to FETCH.
  - Otherwise: hold. Slot contents are stable.
- FLUSH transitions:
  - A further redirect updates pc to the latest target.
  - On ack: discard the data, req_addr←pc (or the same-cycle redirect target), stay asserted, go to FETCH.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 = 32'h0000_0000.
- instr_valid is never 1 in FETCH or FLUSH.

## Timing
- Reset (async, rst_n=0), all outputs immediately:
  - imem_req=0
  - imem_addr=RESET_PC
  - instruction=32'h0
  - instr_pc=32'h0
  - instr_valid=0
  - pc=RESET_PC
  - state=FETCH
- Reset release: imem_req=1 from the first rising edge with rst_n=1.
- Reset asserted mid-operation: any outstanding request is abandoned. A late ack after reset release is not expected.
- Zero-wait memory (ack in the request cycle) with instr_ready held at 1: one instruction every 2 cycles. instr_valid is high in alternate cycles.
- Latency: imem_ack edge → instr_valid=1 on the same rising edge (1 cycle). Accept edge → imem_req=1 on the same rising edge.
- Redirect-to-request latency: 1 edge in FETCH-with-ack and WAIT. In FLUSH and FETCH-without-ack, it is 1 edge after the pending ack.
- Simultaneous redirect_valid and imem_ack in FLUSH: the ack drains the flush, and the next request uses that cycle's redirect target.

## Test plan
- Reset mid-stream:
  - Stimulus: drive rst_n=0 while imem_req=1 and instr_valid=1.
  - Response: within the same cycle, imem_req=0, instr_valid=0, imem_addr=RESET_PC.
  - After release: first request at RESET_PC.
- Zero-wait stream:
  - Stimulus: imem_rdata=~imem_addr, instr_ready=1.
  - Response: (instr_pc, instruction) = (0, FFFFFFFF), (4, FFFFFFFB), (8, FFFFFFF7), each 2 cycles apart.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles after a fetch of 0x10.
  - Response: instr_valid=1 held and instruction stable, imem_req=0. After instr_ready=1, the next imem_addr=0x14.
- Redirect during outstanding request:
  - Stimulus: ack delayed 3 cycles for addr 0x8; redirect_target=0x200 in the first wait cycle.
  - Response: imem_addr stays 0x8 until ack, the returned word never appears on instr_valid, the next request addr is 0x200.
- Redirect on ack cycle and in WAIT:
  - Redirect to 0x103 on the ack cycle: data discarded, next imem_addr=0x100.
  - Redirect to 0x40 in WAIT with instr_ready=1: slot dropped, no transfer, next addr 0x40.
- Wrap:
  - Stimulus: RESET_PC=32'hFFFF_FFFC.
  - Response: instr_pc FFFFFFFC, then 00000000.
